// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - multi-port register file with write bypass and pending scoreboard
//
// Purpose:
//   Architectural register file feeding ID. It has NUM_RD combinational read
//   ports and one synchronous write-back port. A per-register pending bit
//   marks registers whose producer has issued but not yet written back. The
//   hazard unit consumes o_rd_pending to detect RAW hazards.
//
// Ports:
//   i_clk          clock, all state updates on the rising edge
//   i_rst          asynchronous active-low reset
//   i_rd_addr      read indices, port k at [k*ADDR_W +: ADDR_W]
//   o_rd_data      read data, port k at [k*DATA_W +: DATA_W]
//   o_rd_pending   per-port pending flag for the addressed register
//   i_wb_en        write-back enable
//   i_wb_addr      write-back index
//   i_wb_data      write-back data
//   i_rsv_en       reserve a destination register
//   i_rsv_addr     register index to reserve
//   o_pending_cnt  number of registers currently pending
//   o_all_idle     1 when no register is pending
module reg_file_sb #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1,
  parameter int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rd_data,
  output logic [NUM_RD-1:0]        o_rd_pending,
  input  logic                     i_wb_en,
  input  logic [ADDR_W-1:0]        i_wb_addr,
  input  logic [DATA_W-1:0]        i_wb_data,
  input  logic                     i_rsv_en,
  input  logic [ADDR_W-1:0]        i_rsv_addr,
  output logic [CNT_W-1:0]         o_pending_cnt,
  output logic                     o_all_idle
);

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_pend;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_rsv_hits_wb;
  logic              w_set;
  logic              w_clr;
  logic [DEPTH-1:0]  w_pend_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;

  // A reservation of the register being written back makes the new producer
  // the owner, so the bit stays set and the retiring write does not clear it.
  assign w_rsv_hits_wb = i_rsv_en && (i_rsv_addr == i_wb_addr);

  // Counter moves only on real bit transitions, so it tracks the popcount
  // without an adder tree.
  assign w_set = i_rsv_en && !r_pend[i_rsv_addr];
  assign w_clr = i_wb_en && r_pend[i_wb_addr] && !w_rsv_hits_wb;

  always_comb begin
    w_pend_nxt = r_pend;
    if (i_wb_en)  w_pend_nxt[i_wb_addr]  = 1'b0;
    if (i_rsv_en) w_pend_nxt[i_rsv_addr] = 1'b1;
  end

  assign w_cnt_nxt = r_cnt + CNT_W'(w_set) - CNT_W'(w_clr);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      r_pend <= '0;
      r_cnt  <= '0;
    end else begin
      if (i_wb_en) r_regs[i_wb_addr] <= i_wb_data;
      r_pend <= w_pend_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  // Read ports. Outputs are forced to zero while reset is held so a
  // write-back in flight cannot leak through the bypass path.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic              w_hit;

    assign w_ra  = i_rd_addr[k*ADDR_W +: ADDR_W];
    assign w_hit = (BYPASS != 0) && i_wb_en && (i_wb_addr == w_ra);

    assign o_rd_data[k*DATA_W +: DATA_W] = !i_rst ? '0 :
                                           w_hit  ? i_wb_data : r_regs[w_ra];
    assign o_rd_pending[k] = !i_rst ? 1'b0 :
                             w_hit  ? w_rsv_hits_wb : r_pend[w_ra];
  end

  assign o_pending_cnt = r_cnt;
  assign o_all_idle    = (r_cnt == '0);

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - scoreboard bench for reg_file_sb (bypass and non-bypass instances)
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rd_addr = '0;
  logic        wb_en = 1'b0;
  logic [3:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        rsv_en = 1'b0;
  logic [3:0]  rsv_addr = '0;

  logic [63:0] rd_data;
  logic [1:0]  rd_pend;
  logic [4:0]  cnt;
  logic        idle;
  logic [63:0] nb_rd_data;
  logic [1:0]  nb_rd_pend;
  logic [4:0]  nb_cnt;
  logic        nb_idle;

  reg_file_sb #(.BYPASS(1)) u_dut (
    .i_clk(clk), .i_rst(rst_n), .i_rd_addr(rd_addr),
    .o_rd_data(rd_data), .o_rd_pending(rd_pend),
    .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
    .i_rsv_en(rsv_en), .i_rsv_addr(rsv_addr),
    .o_pending_cnt(cnt), .o_all_idle(idle)
  );

  reg_file_sb #(.BYPASS(0)) u_dut_nb (
    .i_clk(clk), .i_rst(rst_n), .i_rd_addr(rd_addr),
    .o_rd_data(nb_rd_data), .o_rd_pending(nb_rd_pend),
    .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
    .i_rsv_en(rsv_en), .i_rsv_addr(rsv_addr),
    .o_pending_cnt(nb_cnt), .o_all_idle(nb_idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_cyc = 0;
  logic [31:0] m_regs [16];
  logic [15:0] m_pend;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_pend = '0;
  endtask

  function automatic int popcnt(input logic [15:0] v);
    int c = 0;
    for (int i = 0; i < 16; i++) c += int'(v[i]);
    return c;
  endfunction

  function automatic logic [31:0] exp_rd(input logic rn, input logic [3:0] a, input logic byp);
    if (!rn) return 32'h0;
    if (byp && wb_en && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] exp_pend(input logic rn, input logic [3:0] a);
    if (!rn) return 32'h0;
    if (wb_en && wb_addr == a) return {31'h0, rsv_en && rsv_addr == wb_addr};
    return {31'h0, m_pend[a]};
  endfunction

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = $sformatf("%s@%0d", tag, n_cyc);
    e.v   = v;
    exp_q.push_back(e);
  endtask

  // One clock: drive inputs, push expectations, compare mid-cycle, advance model.
  task automatic cycle(input logic rn, input logic we, input logic [3:0] wa,
                       input logic [31:0] wd, input logic re, input logic [3:0] ra,
                       input logic [3:0] a0, input logic [3:0] a1);
    logic [31:0] obs [8];
    exp_t        e;
    rst_n = rn; wb_en = we; wb_addr = wa; wb_data = wd;
    rsv_en = re; rsv_addr = ra; rd_addr = {a1, a0};
    if (!rn) model_clear();
    push("rd0",    exp_rd(rn, a0, 1'b1));
    push("rd1",    exp_rd(rn, a1, 1'b1));
    push("pend0",  exp_pend(rn, a0));
    push("pend1",  exp_pend(rn, a1));
    push("cnt",    32'(popcnt(m_pend)));
    push("idle",   {31'h0, m_pend == 16'h0});
    push("nb_rd0", exp_rd(rn, a0, 1'b0));
    push("nb_pend0", rn ? {31'h0, m_pend[a0]} : 32'h0);
    @(negedge clk);
    obs[0] = rd_data[31:0];
    obs[1] = rd_data[63:32];
    obs[2] = {31'h0, rd_pend[0]};
    obs[3] = {31'h0, rd_pend[1]};
    obs[4] = {27'h0, cnt};
    obs[5] = {31'h0, idle};
    obs[6] = nb_rd_data[31:0];
    obs[7] = {31'h0, nb_rd_pend[0]};
    for (int i = 0; i < 8; i++) begin
      if (exp_q.size() == 0) begin
        chk("queue_underflow", 32'h0, 32'h1);
      end else begin
        e = exp_q.pop_front();
        chk(e.tag, obs[i], e.v);
      end
    end
    @(posedge clk);
    if (rn) begin
      if (we) begin
        m_regs[wa] = wd;
        m_pend[wa] = 1'b0;
      end
      if (re) m_pend[ra] = 1'b1;
    end
    n_cyc++;
    #1;
  endtask

  initial begin
    model_clear();
    // Reset held with a write-back in flight; the bypass must not leak it.
    cycle(1'b0, 1'b1, 4'd3, 32'hDEADBEEF, 1'b1, 4'd3, 4'd3, 4'd3);
    cycle(1'b0, 1'b1, 4'd3, 32'hDEADBEEF, 1'b1, 4'd3, 4'd3, 4'd3);
    for (int i = 0; i < 16; i++)
      cycle(1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'(i), 4'(15 - i));

    // Write then read on both ports.
    cycle(1'b1, 1'b1, 4'd5, 32'h12345678, 1'b0, 4'd0, 4'd0, 4'd1);
    cycle(1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd5, 4'd5);
    chk("r5_port0_lit", rd_data[31:0], 32'h12345678);
    chk("r5_port1_lit", rd_data[63:32], 32'h12345678);

    // Bypass versus stored value.
    cycle(1'b1, 1'b1, 4'd7, 32'h11111111, 1'b0, 4'd0, 4'd0, 4'd0);
    cycle(1'b1, 1'b1, 4'd7, 32'hA5A5A5A5, 1'b0, 4'd0, 4'd7, 4'd5);
    cycle(1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd7, 4'd7);

    // Scoreboard lifecycle.
    cycle(1'b1, 1'b0, 4'd0, 32'h0, 1'b1, 4'd2, 4'd2, 4'd9);
    cycle(1'b1, 1'b0, 4'd0, 32'h0, 1'b1, 4'd9, 4'd2, 4'd9);
    cycle(1'b1, 1'b1, 4'd2, 32'h22, 1'b0, 4'd0, 4'd2, 4'd9);
    cycle(1'b1, 1'b1, 4'd9, 32'h99, 1'b0, 4'd0, 4'd2, 4'd9);
    cycle(1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd2, 4'd9);
    chk("idle_after_lifecycle", {31'h0, idle}, 32'h1);

    // Simultaneous reserve and write-back on an already pending register.
    cycle(1'b1, 1'b0, 4'd0, 32'h0, 1'b1, 4'd4, 4'd4, 4'd0);
    cycle(1'b1, 1'b1, 4'd4, 32'h77, 1'b1, 4'd4, 4'd4, 4'd0);
    cycle(1'b1, 1'b0, 4'd0, 32'h0, 1'b1, 4'd4, 4'd4, 4'd4);
    cycle(1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd4, 4'd4);
    chk("r4_pend_cnt_lit", {27'h0, cnt}, 32'd1);
    // Write-back to a non-pending register keeps it clear.
    cycle(1'b1, 1'b1, 4'd6, 32'h66, 1'b0, 4'd0, 4'd6, 4'd4);
    cycle(1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd6, 4'd4);

    // Fill every register, then reset in the middle of a cycle.
    for (int i = 0; i < 16; i++)
      cycle(1'b1, 1'b0, 4'd0, 32'h0, 1'b1, 4'(i), 4'(i), 4'd0);
    cycle(1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd3, 4'd15);
    chk("full_cnt_lit", {27'h0, cnt}, 32'd16);
    wb_en = 1'b1; wb_addr = 4'd3; wb_data = 32'hCAFEF00D; rd_addr = {4'd3, 4'd3};
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_cnt", {27'h0, cnt}, 32'h0);
    chk("midrst_pend", {30'h0, rd_pend}, 32'h0);
    chk("midrst_idle", {31'h0, idle}, 32'h1);
    chk("midrst_rd0", rd_data[31:0], 32'h0);
    @(posedge clk); #1;
    model_clear();
    cycle(1'b0, 1'b1, 4'd3, 32'hCAFEF00D, 1'b1, 4'd3, 4'd3, 4'd4);
    cycle(1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd3, 4'd4);

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++)
      cycle($urandom_range(0, 49) != 0, 1'($urandom), 4'($urandom), $urandom,
            1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
